// File: rtl/bsg_nasti_server_req.sv
// NASTI request-tunnel far-side decoder: rebuilds AR, AW and W channel beats
// from the serialized tunnel packet stream produced by the client packer.

package bsg_nasti_pkg;

    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic        user;
    } bsg_nasti_a_pkt;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [4:0]  id;
        logic        user;
    } bsg_nasti_w_pkt;

    typedef logic [64:0] bsg_tun_dmx_t;

    // Address packet, padded to the tunnel width.
    typedef struct packed {
        logic [26:0] pad;
        logic        rw;
        logic [4:0]  id;
        logic [31:0] addr;
    } bsg_nasti_sa_pkt;

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } bsg_nasti_sw_pkt;

endpackage

module bsg_nasti_server_req
    import bsg_nasti_pkg::*;
#(
    parameter int unsigned beats_p = 4,
    parameter int unsigned size_p  = 3
) (
    input  logic           clk_i,
    input  logic           reset_i,

    input  logic           req_valid_i,
    input  bsg_tun_dmx_t   req_data_i,
    output logic           req_yumi_o,

    output logic           nasti_ar_valid_o,
    output bsg_nasti_a_pkt nasti_ar_data_o,
    input  logic           nasti_ar_ready_i,

    output logic           nasti_aw_valid_o,
    output bsg_nasti_a_pkt nasti_aw_data_o,
    input  logic           nasti_aw_ready_i,

    output logic           nasti_w_valid_o,
    output bsg_nasti_w_pkt nasti_w_data_o,
    input  logic           nasti_w_ready_i,

    output logic           err_o
);

    localparam int unsigned CntW = $clog2(beats_p) + 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(beats_p - 1);
    localparam logic [CntW-1:0] CntMax   = CntW'(beats_p);

    typedef enum logic [2:0] {StIdle, StArOut, StAwOut, StWWait, StWOut} state_e;

    state_e          state_q, state_d;
    bsg_nasti_a_pkt  a_q, a_d;
    bsg_nasti_w_pkt  w_q, w_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            yumi;

    bsg_nasti_sa_pkt sa;
    bsg_nasti_sw_pkt sw;
    logic            unused_pad;

    assign sa         = bsg_nasti_sa_pkt'(req_data_i);
    assign sw         = bsg_nasti_sw_pkt'(req_data_i);
    assign unused_pad = ^sa.pad;

    function automatic bsg_nasti_a_pkt build_a(bsg_nasti_sa_pkt p);
        bsg_nasti_a_pkt a;
        a       = '0;
        a.addr  = p.addr;
        a.id    = p.id;
        a.len   = 8'(beats_p - 1);
        a.size  = 3'(size_p);
        a.burst = 2'b01;
        return a;
    endfunction

    function automatic bsg_nasti_w_pkt build_w(bsg_nasti_sw_pkt p);
        bsg_nasti_w_pkt w;
        w      = '0;
        w.data = p.data;
        w.last = p.last;
        w.strb = '1;
        return w;
    endfunction

    always_comb begin
        logic a_take;
        logic w_take;
        state_d = state_q;
        a_d     = a_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        yumi    = 1'b0;
        a_take  = 1'b0;
        w_take  = 1'b0;

        unique case (state_q)
            StIdle: begin
                a_take = req_valid_i;
            end
            StArOut: begin
                if (nasti_ar_ready_i) begin
                    if (req_valid_i) a_take = 1'b1;
                    else             state_d = StIdle;
                end
            end
            StAwOut: begin
                if (nasti_aw_ready_i) begin
                    state_d = StWWait;
                    cnt_d   = '0;
                end
            end
            StWWait: begin
                w_take = req_valid_i;
            end
            StWOut: begin
                if (nasti_w_ready_i) begin
                    if (w_q.last)         state_d = StIdle;
                    else if (req_valid_i) w_take  = 1'b1;
                    else                  state_d = StWWait;
                end
            end
            default: state_d = StIdle;
        endcase

        if (a_take) begin
            yumi    = 1'b1;
            a_d     = build_a(sa);
            state_d = sa.rw ? StAwOut : StArOut;
        end

        // cnt_q is the index of the beat being captured; both malformed
        // shapes are flagged but the beat is still forwarded as received.
        if (w_take) begin
            yumi    = 1'b1;
            w_d     = build_w(sw);
            state_d = StWOut;
            if ((sw.last && (cnt_q != LastBeat)) || (!sw.last && (cnt_q == LastBeat))) begin
                err_d = 1'b1;
            end
            if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            w_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Handshake is suppressed while reset is held so no packet is lost.
    assign req_yumi_o       = yumi & ~reset_i;
    assign nasti_ar_valid_o = (state_q == StArOut);
    assign nasti_aw_valid_o = (state_q == StAwOut);
    assign nasti_w_valid_o  = (state_q == StWOut);
    assign nasti_ar_data_o  = a_q;
    assign nasti_aw_data_o  = a_q;
    assign nasti_w_data_o   = w_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_bsg_nasti_server_req.sv
// Directed bench for bsg_nasti_server_req: reads, writes, backpressure,
// streaming, burst-length error and mid-burst reset.

module tb_bsg_nasti_server_req;
    import bsg_nasti_pkg::*;

    logic           clk = 1'b0;
    logic           reset_i;
    logic           req_valid_i;
    bsg_tun_dmx_t   req_data_i;
    logic           req_yumi_o;
    logic           nasti_ar_valid_o;
    bsg_nasti_a_pkt nasti_ar_data_o;
    logic           nasti_ar_ready_i;
    logic           nasti_aw_valid_o;
    bsg_nasti_a_pkt nasti_aw_data_o;
    logic           nasti_aw_ready_i;
    logic           nasti_w_valid_o;
    bsg_nasti_w_pkt nasti_w_data_o;
    logic           nasti_w_ready_i;
    logic           err_o;

    int n_checks = 0;
    int n_fails  = 0;

    bsg_nasti_server_req #(.beats_p(4), .size_p(3)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .req_valid_i      (req_valid_i),
        .req_data_i       (req_data_i),
        .req_yumi_o       (req_yumi_o),
        .nasti_ar_valid_o (nasti_ar_valid_o),
        .nasti_ar_data_o  (nasti_ar_data_o),
        .nasti_ar_ready_i (nasti_ar_ready_i),
        .nasti_aw_valid_o (nasti_aw_valid_o),
        .nasti_aw_data_o  (nasti_aw_data_o),
        .nasti_aw_ready_i (nasti_aw_ready_i),
        .nasti_w_valid_o  (nasti_w_valid_o),
        .nasti_w_data_o   (nasti_w_data_o),
        .nasti_w_ready_i  (nasti_w_ready_i),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    function automatic bsg_tun_dmx_t mk_sa(logic [31:0] addr, logic [4:0] id, logic rw);
        bsg_nasti_sa_pkt p;
        p      = '0;
        p.addr = addr;
        p.id   = id;
        p.rw   = rw;
        return bsg_tun_dmx_t'(p);
    endfunction

    function automatic bsg_tun_dmx_t mk_sw(logic [63:0] data, logic last);
        bsg_nasti_sw_pkt p;
        p.data = data;
        p.last = last;
        return bsg_tun_dmx_t'(p);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; req_valid_i = 1'b0; req_data_i = '0;
        nasti_ar_ready_i = 1'b0; nasti_aw_ready_i = 1'b0; nasti_w_ready_i = 1'b0;
        step(); step();
        n_checks++; if ({nasti_ar_valid_o, nasti_aw_valid_o, nasti_w_valid_o} !== 3'b000) begin
            $display("FAIL reset_valids: got %b want 000",
                     {nasti_ar_valid_o, nasti_aw_valid_o, nasti_w_valid_o}); n_fails++; end
        n_checks++; if (req_yumi_o !== 1'b0) begin
            $display("FAIL reset_yumi: got %b want 0", req_yumi_o); n_fails++; end
        n_checks++; if (err_o !== 1'b0) begin
            $display("FAIL reset_err: got %b want 0", err_o); n_fails++; end
        n_checks++; if (nasti_ar_data_o !== '0 || nasti_w_data_o !== '0) begin
            $display("FAIL reset_data: got ar=%h w=%h want 0", nasti_ar_data_o, nasti_w_data_o);
            n_fails++; end
        reset_i = 1'b0;
        step();
    endtask

    task automatic test_read();
        req_data_i = mk_sa(32'h1000, 5'd3, 1'b0); req_valid_i = 1'b1; nasti_ar_ready_i = 1'b1;
        #1;
        n_checks++; if (req_yumi_o !== 1'b1 || nasti_ar_valid_o !== 1'b0) begin
            $display("FAIL read_accept: got yumi=%b arv=%b want 1 0", req_yumi_o, nasti_ar_valid_o);
            n_fails++; end
        step();
        req_valid_i = 1'b0;
        #1;
        n_checks++; if (nasti_ar_valid_o !== 1'b1 || nasti_aw_valid_o !== 1'b0) begin
            $display("FAIL read_arvalid: got arv=%b awv=%b want 1 0", nasti_ar_valid_o,
                     nasti_aw_valid_o); n_fails++; end
        n_checks++; if (nasti_ar_data_o.addr !== 32'h1000 || nasti_ar_data_o.id !== 5'd3) begin
            $display("FAIL read_addr_id: got %h/%0d want 1000/3", nasti_ar_data_o.addr,
                     nasti_ar_data_o.id); n_fails++; end
        n_checks++; if (nasti_ar_data_o.len !== 8'd3 || nasti_ar_data_o.size !== 3'd3 ||
                        nasti_ar_data_o.burst !== 2'b01 || nasti_ar_data_o.cache !== 4'd0) begin
            $display("FAIL read_fields: got len=%0d size=%0d burst=%b cache=%h want 3 3 01 0",
                     nasti_ar_data_o.len, nasti_ar_data_o.size, nasti_ar_data_o.burst,
                     nasti_ar_data_o.cache); n_fails++; end
        step();
        n_checks++; if (nasti_ar_valid_o !== 1'b0) begin
            $display("FAIL read_done: got arv=%b want 0", nasti_ar_valid_o); n_fails++; end
    endtask

    task automatic test_write();
        logic [63:0] d [4];
        for (int i = 0; i < 4; i++) d[i] = 64'hA5A5_0000_0000_0000 + 64'(i);
        nasti_aw_ready_i = 1'b1; nasti_w_ready_i = 1'b1;
        req_data_i = mk_sa(32'h2000, 5'd5, 1'b1); req_valid_i = 1'b1;
        step();
        req_data_i = mk_sw(d[0], 1'b0);
        #1;
        n_checks++; if (nasti_aw_valid_o !== 1'b1 || nasti_aw_data_o.addr !== 32'h2000 ||
                        nasti_aw_data_o.id !== 5'd5 || nasti_aw_data_o.len !== 8'd3) begin
            $display("FAIL write_aw: got v=%b addr=%h id=%0d len=%0d want 1 2000 5 3",
                     nasti_aw_valid_o, nasti_aw_data_o.addr, nasti_aw_data_o.id,
                     nasti_aw_data_o.len); n_fails++; end
        n_checks++; if (req_yumi_o !== 1'b0) begin
            $display("FAIL write_aw_nobypass: got yumi=%b want 0", req_yumi_o); n_fails++; end
        step();
        n_checks++; if (req_yumi_o !== 1'b1 || nasti_w_valid_o !== 1'b0) begin
            $display("FAIL write_wwait: got yumi=%b wv=%b want 1 0", req_yumi_o, nasti_w_valid_o);
            n_fails++; end
        step();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) req_data_i = mk_sw(d[i+1], (i + 1) == 3);
            else       req_valid_i = 1'b0;
            #1;
            n_checks++; if (nasti_w_valid_o !== 1'b1 || nasti_w_data_o.data !== d[i] ||
                            nasti_w_data_o.last !== (i == 3) || nasti_w_data_o.strb !== 8'hff) begin
                $display("FAIL write_beat%0d: got v=%b data=%h last=%b strb=%h want 1 %h %b ff",
                         i, nasti_w_valid_o, nasti_w_data_o.data, nasti_w_data_o.last,
                         nasti_w_data_o.strb, d[i], (i == 3)); n_fails++; end
            n_checks++; if (req_yumi_o !== (i < 3)) begin
                $display("FAIL write_bypass%0d: got yumi=%b want %b", i, req_yumi_o, (i < 3));
                n_fails++; end
            step();
        end
        n_checks++; if (nasti_w_valid_o !== 1'b0 || err_o !== 1'b0) begin
            $display("FAIL write_end: got wv=%b err=%b want 0 0", nasti_w_valid_o, err_o);
            n_fails++; end
    endtask

    task automatic test_backpressure();
        logic [63:0] d [4];
        for (int i = 0; i < 4; i++) d[i] = 64'hB000_0000_1111_0000 + 64'(i * 3);
        nasti_aw_ready_i = 1'b1; nasti_w_ready_i = 1'b1;
        req_data_i = mk_sa(32'h4000, 5'd1, 1'b1); req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        step();
        req_data_i = mk_sw(d[0], 1'b0); req_valid_i = 1'b1;
        step();
        nasti_w_ready_i = 1'b0; req_data_i = mk_sw(d[1], 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (nasti_w_valid_o !== 1'b1 || nasti_w_data_o.data !== d[0] ||
                            req_yumi_o !== 1'b0) begin
                $display("FAIL bp_stall%0d: got v=%b data=%h yumi=%b want 1 %h 0", c,
                         nasti_w_valid_o, nasti_w_data_o.data, req_yumi_o, d[0]); n_fails++; end
            step();
        end
        nasti_w_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) req_data_i = mk_sw(d[i+1], (i + 1) == 3);
            else       req_valid_i = 1'b0;
            #1;
            n_checks++; if (nasti_w_valid_o !== 1'b1 || nasti_w_data_o.data !== d[i] ||
                            nasti_w_data_o.last !== (i == 3)) begin
                $display("FAIL bp_beat%0d: got v=%b data=%h last=%b want 1 %h %b", i,
                         nasti_w_valid_o, nasti_w_data_o.data, nasti_w_data_o.last, d[i], (i == 3));
                n_fails++; end
            step();
        end
        n_checks++; if (nasti_w_valid_o !== 1'b0 || err_o !== 1'b0) begin
            $display("FAIL bp_end: got wv=%b err=%b want 0 0", nasti_w_valid_o, err_o);
            n_fails++; end
    endtask

    task automatic test_streaming();
        logic [31:0] a [4];
        for (int i = 0; i < 4; i++) a[i] = 32'h8000 + 32'(i * 32'h100);
        nasti_ar_ready_i = 1'b1;
        req_data_i = mk_sa(a[0], 5'd0, 1'b0); req_valid_i = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                nasti_ar_ready_i = 1'b0; req_data_i = mk_sa(a[2], 5'd2, 1'b0);
                #1;
                n_checks++; if (req_yumi_o !== 1'b0 || nasti_ar_data_o.addr !== a[1]) begin
                    $display("FAIL stream_hold: got yumi=%b addr=%h want 0 %h", req_yumi_o,
                             nasti_ar_data_o.addr, a[1]); n_fails++; end
                step();
                nasti_ar_ready_i = 1'b1;
            end
            if (i < 3) req_data_i = mk_sa(a[i+1], 5'(i + 1), 1'b0);
            else       req_valid_i = 1'b0;
            #1;
            n_checks++; if (nasti_ar_valid_o !== 1'b1 || nasti_ar_data_o.addr !== a[i] ||
                            nasti_ar_data_o.id !== 5'(i) || req_yumi_o !== (i < 3)) begin
                $display("FAIL stream_ar%0d: got v=%b addr=%h id=%0d yumi=%b want 1 %h %0d %b", i,
                         nasti_ar_valid_o, nasti_ar_data_o.addr, nasti_ar_data_o.id, req_yumi_o,
                         a[i], i, (i < 3)); n_fails++; end
            step();
        end
        n_checks++; if (nasti_ar_valid_o !== 1'b0) begin
            $display("FAIL stream_end: got arv=%b want 0", nasti_ar_valid_o); n_fails++; end
    endtask

    task automatic test_error();
        nasti_aw_ready_i = 1'b1; nasti_w_ready_i = 1'b1; nasti_ar_ready_i = 1'b1;
        req_data_i = mk_sa(32'h5000, 5'd2, 1'b1); req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        step();
        req_data_i = mk_sw(64'h1, 1'b0); req_valid_i = 1'b1;
        step();
        req_data_i = mk_sw(64'h2, 1'b1);
        #1;
        n_checks++; if (err_o !== 1'b0) begin
            $display("FAIL err_early: got err=%b want 0", err_o); n_fails++; end
        step();
        req_data_i = mk_sa(32'h6000, 5'd7, 1'b0);
        #1;
        n_checks++; if (err_o !== 1'b1 || nasti_w_data_o.last !== 1'b1 ||
                        nasti_w_data_o.data !== 64'h2) begin
            $display("FAIL err_set: got err=%b last=%b data=%h want 1 1 2", err_o,
                     nasti_w_data_o.last, nasti_w_data_o.data); n_fails++; end
        n_checks++; if (req_yumi_o !== 1'b0) begin
            $display("FAIL err_last_nobypass: got yumi=%b want 0", req_yumi_o); n_fails++; end
        step();
        n_checks++; if (req_yumi_o !== 1'b1) begin
            $display("FAIL err_next_accept: got yumi=%b want 1", req_yumi_o); n_fails++; end
        step();
        req_valid_i = 1'b0;
        #1;
        n_checks++; if (nasti_ar_valid_o !== 1'b1 || nasti_ar_data_o.addr !== 32'h6000 ||
                        nasti_ar_data_o.id !== 5'd7 || err_o !== 1'b1) begin
            $display("FAIL err_next_ar: got v=%b addr=%h id=%0d err=%b want 1 6000 7 1",
                     nasti_ar_valid_o, nasti_ar_data_o.addr, nasti_ar_data_o.id, err_o);
            n_fails++; end
        step(); step();
        n_checks++; if (err_o !== 1'b1) begin
            $display("FAIL err_sticky: got err=%b want 1", err_o); n_fails++; end
    endtask

    task automatic test_reset_mid_burst();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        n_checks++; if (err_o !== 1'b0) begin
            $display("FAIL rst_err_clear: got err=%b want 0", err_o); n_fails++; end
        nasti_aw_ready_i = 1'b1; nasti_w_ready_i = 1'b1; nasti_ar_ready_i = 1'b1;
        req_data_i = mk_sa(32'h7000, 5'd4, 1'b1); req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        step();
        req_data_i = mk_sw(64'hC0, 1'b0); req_valid_i = 1'b1;
        step();
        req_data_i = mk_sw(64'hC1, 1'b0);
        step();
        nasti_w_ready_i = 1'b0; req_data_i = mk_sw(64'hC2, 1'b0);
        #1;
        n_checks++; if (nasti_w_valid_o !== 1'b1 || nasti_w_data_o.data !== 64'hC1) begin
            $display("FAIL rst_pre: got wv=%b data=%h want 1 c1", nasti_w_valid_o,
                     nasti_w_data_o.data); n_fails++; end
        reset_i = 1'b1;
        #1;
        n_checks++; if ({nasti_ar_valid_o, nasti_aw_valid_o, nasti_w_valid_o} !== 3'b000 ||
                        req_yumi_o !== 1'b0 || err_o !== 1'b0 || nasti_w_data_o !== '0) begin
            $display("FAIL rst_async: got valids=%b yumi=%b err=%b wdata=%h want 000 0 0 0",
                     {nasti_ar_valid_o, nasti_aw_valid_o, nasti_w_valid_o}, req_yumi_o, err_o,
                     nasti_w_data_o); n_fails++; end
        step();
        reset_i = 1'b0;
        req_data_i = mk_sa(32'h3000, 5'd0, 1'b0);
        #1;
        n_checks++; if (req_yumi_o !== 1'b1) begin
            $display("FAIL rst_next_accept: got yumi=%b want 1", req_yumi_o); n_fails++; end
        step();
        req_valid_i = 1'b0;
        #1;
        n_checks++; if (nasti_ar_valid_o !== 1'b1 || nasti_ar_data_o.addr !== 32'h3000 ||
                        nasti_aw_valid_o !== 1'b0 || nasti_w_valid_o !== 1'b0) begin
            $display("FAIL rst_next_ar: got arv=%b addr=%h awv=%b wv=%b want 1 3000 0 0",
                     nasti_ar_valid_o, nasti_ar_data_o.addr, nasti_aw_valid_o, nasti_w_valid_o);
            n_fails++; end
        step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_backpressure();
        test_streaming();
        test_error();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
